mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters: the pipeline's IF stage (read-only fetch) and MEM stage (load/store).
- Runs a fixed-latency memory transaction through an IDLE→ISSUE→WAIT→DONE state machine.
- Returns read data with a one-cycle ack pulse and produces stall signals for the pipeline hazard logic.
- Data accesses have priority; a streak limit prevents fetch starvation.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width.
- LAT, 2, memory read/write latency in cycles from mem_en sample to mem_rdata valid; legal range 1..15.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  AW  fetch word address
- if_rdata  out  DW  fetch data; valid while if_ack=1, held afterwards
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata stable until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data; valid while dm_ack=1
- dm_ack  out  1  one-cycle completion pulse for data (both loads and stores)
- mem_en  out  1  memory access strobe, registered, exactly one cycle per transaction
- mem_we  out  1  memory write enable; qualified by mem_en
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data; valid LAT cycles after the mem_en cycle
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  dm_req & ~dm_ack (combinational)

Behaviour:
- Reset (asynchronous, active-low; clock is clock):
  - state=IDLE.
  - mem_en, mem_we, if_ack, dm_ack, streak counter and latency counter = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Reset asserted mid-transaction abandons it: no ack is issued, and a late mem_rdata is ignored.
- IDLE:
  - Requests are sampled only in this state.
  - If no request: remain in IDLE.
  - If only one request is high: grant it.
  - If both are high: grant data, unless streak==STARVE_LIMIT, in which case grant fetch.
  - On a grant: register addr/we/wdata into mem_* (mem_we=0 for fetch), record the grant owner, go to ISSUE.
- ISSUE:
  - mem_en=1 for this single cycle.
  - Latency counter loads LAT-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where the counter reads 0, mem_rdata is valid and is captured into the owner's rdata register; go to DONE.
- DONE:
  - Owner's ack=1 for one cycle; return to IDLE.
  - Request lines seen during DONE belong to the completed transaction and are ignored.
  - A request still high in the following IDLE cycle is a new request.
- Latency: for a request first seen in IDLE cycle t, mem_en is high in t+1 and ack is high in t+LAT+2.
  - Back-to-back throughput is one transaction per LAT+3 cycles.
- Stores: mem_rdata is not captured and dm_rdata holds its previous value; dm_ack follows the same timing as a load.
- Streak counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, or on a data grant while if_req=0.
- Only one transaction is outstanding at any time; the non-owner's stall stays high throughout.
- No ack is ever issued without a prior grant, and never to both requesters in the same cycle.
- A request deasserted before its ack is a protocol violation; the arbiter completes the transaction anyway and still pulses ack.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding localparams S_IDLE, S_ISSUE, S_WAIT, S_DONE (2 bits).
  - Owner encoding OWN_IF=0, OWN_DM=1.
  - Parameter-range check constants.
- One natural sub-module: arb_streak_counter (saturating counter with increment/clear/at-limit outputs).
- The FSM, latency counter and output registers stay in mem_port_arbiter.

Test Plan:
- LAT=2; if_req=1, if_addr=0x004 at cycle 0 → mem_en=1, mem_we=0, mem_addr=0x004 in cycle 1; memory returns 0x8C010000 in cycle 3 → if_ack=1, if_rdata=0x8C010000 in cycle 4; stall_if=1 in cycles 0–3.
- Both requests at cycle 0 (dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF) → data granted first: mem_en, mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; dm_ack in cycle 4; fetch mem_en in cycle 6; if_ack in cycle 9.
- STARVE_LIMIT=4; dm_req and if_req held high continuously → grant order DM, DM, DM, DM, IF, DM…; streak returns to 0 after the IF grant.
- Load at dm_addr=0x020 whose memory data is 0x00000005 → dm_ack pulses for exactly one cycle with dm_rdata=5; dm_req kept high through the next IDLE starts a second transaction (mem_en again two cycles after the ack).
- reset driven low during WAIT → all outputs 0 immediately; no ack is produced after reset releases, even though mem_rdata arrives; a new if_req then completes normally with LAT+2 latency.
- LAT=1 and LAT=15 configurations, one fetch each → ack observed at t+3 and t+17 respectively.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared state/owner encodings and parameter limits for the
//               unified memory port arbiter.            Revision 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 15;
    localparam int STARVE_MIN = 1;
    localparam int STARVE_MAX = 15;
    localparam int CNT_W      = 4;

    function automatic bit params_legal(input int lat, input int starve);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX) &&
               (starve >= STARVE_MIN) && (starve <= STARVE_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch, data and memory-side signals of the arbiter.
//                                                       Revision 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    // Pipeline plus memory side drives the arbiter inputs.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface
`default_nettype wire

// File: rtl/arb_streak_counter.sv
`default_nettype none
// ============================================================================
// arb_streak_counter : saturating count of data grants won over a waiting
//                      fetch; at-limit forces the next fetch grant. Rev 1.0
// ============================================================================
module arb_streak_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_at_limit
);
    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one single-ported memory between fetch and data
//                    requesters through an IDLE/ISSUE/WAIT/DONE sequence. Rev 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int LAT          = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic            clock,
    input  wire logic            reset,
    mem_port_arbiter_if.slave    bus
);

    generate
        if (!params_legal(LAT, STARVE_LIMIT)) begin : g_param_check
            $error("mem_port_arbiter: LAT and STARVE_LIMIT must lie in 1..15");
        end
    endgenerate

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_owner_t       r_owner;
    logic [CNT_W-1:0] r_lat_cnt;
    logic             r_mem_en;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [DW-1:0]    r_if_rdata;
    logic [DW-1:0]    r_dm_rdata;
    logic             r_if_ack;
    logic             r_dm_ack;

    logic             w_grant;
    logic             w_grant_dm;
    logic             w_capture;
    logic             w_at_limit;
    logic             w_streak_inc;
    logic             w_streak_clr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests are only looked at in IDLE, so lines still high during DONE
    // are attributed to the transaction that just finished.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_dm  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_grant     = 1'b1;
                    w_grant_dm  = bus.dm_req && !(bus.if_req && w_at_limit);
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_streak_inc = w_grant && w_grant_dm && bus.if_req;
    assign w_streak_clr = w_grant && !(w_grant_dm && bus.if_req);

    arb_streak_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_streak (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_streak_inc),
        .i_clr      (w_streak_clr),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner     <= OWN_IF;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
        end else begin
            r_mem_en <= w_grant;
            if (w_grant) begin
                r_owner    <= w_grant_dm ? OWN_DM : OWN_IF;
                r_mem_addr <= w_grant_dm ? bus.dm_addr : bus.if_addr;
                r_mem_we   <= w_grant_dm && bus.dm_we;
                if (w_grant_dm) begin
                    r_mem_wdata <= bus.dm_wdata;
                end
            end

            if (r_state == S_ISSUE) begin
                r_lat_cnt <= CNT_W'(LAT - 1);
            end else if ((r_state == S_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            // Stores leave the data read register untouched.
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= bus.mem_rdata;
                end else if (!r_mem_we) begin
                    r_dm_rdata <= bus.mem_rdata;
                end
            end

            r_if_ack <= w_capture && (r_owner == OWN_IF);
            r_dm_ack <= w_capture && (r_owner == OWN_DM);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed bench for the memory port arbiter with LAT
//                       2, 1 and 15 instances.                Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.AW(10), .DW(32)) b   ();
    mem_port_arbiter_if #(.AW(10), .DW(32)) b1  ();
    mem_port_arbiter_if #(.AW(10), .DW(32)) b15 ();

    mem_port_arbiter #(.AW(10), .DW(32), .LAT(2),  .STARVE_LIMIT(4)) dut   (.clock(clock), .reset(reset), .bus(b));
    mem_port_arbiter #(.AW(10), .DW(32), .LAT(1),  .STARVE_LIMIT(4)) dut1  (.clock(clock), .reset(reset), .bus(b1));
    mem_port_arbiter #(.AW(10), .DW(32), .LAT(15), .STARVE_LIMIT(4)) dut15 (.clock(clock), .reset(reset), .bus(b15));

    // Memory models: read data appears exactly LAT cycles after the mem_en cycle,
    // otherwise a poison value.
    logic [31:0] mem [0:1023];
    logic [31:0] p2  [0:1];
    logic [31:0] p1;
    logic [31:0] p15 [0:14];

    always @(posedge clock) begin
        if (b.mem_en && b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
        p2[1] <= p2[0];
        p2[0] <= (b.mem_en && !b.mem_we) ? mem[b.mem_addr] : 32'hBAD0_0002;
        p1    <= b1.mem_en ? mem[b1.mem_addr] : 32'hBAD0_0001;
        for (int i = 14; i > 0; i--) p15[i] <= p15[i-1];
        p15[0] <= b15.mem_en ? mem[b15.mem_addr] : 32'hBAD0_000F;
    end
    assign b.mem_rdata   = p2[1];
    assign b1.mem_rdata  = p1;
    assign b15.mem_rdata = p15[14];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({b.mem_en, b.mem_we, b.if_ack, b.dm_ack} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {b.mem_en, b.mem_we, b.if_ack, b.dm_ack});
        end
        n_checks++;
        if ({b.mem_addr, b.mem_wdata, b.if_rdata, b.dm_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h expected 0", b.mem_addr, b.mem_wdata, b.if_rdata, b.dm_rdata);
        end
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if ({b.mem_en, b1.mem_en, b15.mem_en, b.stall_if, b.stall_mem} !== 5'b0) begin
            n_fail++; $display("FAIL idle_no_req: got %b expected 00000", {b.mem_en, b1.mem_en, b15.mem_en, b.stall_if, b.stall_mem});
        end
    endtask

    task automatic test_fetch();
        b.if_addr = 10'h004; b.if_req = 1'b1;
        #1;
        n_checks++;
        if ({b.stall_if, b.mem_en} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_c0: got stall/en %b expected 10", {b.stall_if, b.mem_en});
        end
        tick();
        n_checks++;
        if ({b.mem_en, b.mem_we, b.mem_addr, b.stall_if} !== {1'b1, 1'b0, 10'h004, 1'b1}) begin
            n_fail++; $display("FAIL fetch_issue: got en=%b we=%b addr=%h stall=%b expected 1 0 004 1", b.mem_en, b.mem_we, b.mem_addr, b.stall_if);
        end
        tick(); tick();
        n_checks++;
        if ({b.stall_if, b.if_ack, b.mem_en} !== 3'b100) begin
            n_fail++; $display("FAIL fetch_c3: got stall/ack/en %b expected 100", {b.stall_if, b.if_ack, b.mem_en});
        end
        tick();
        n_checks++;
        if ({b.if_ack, b.dm_ack, b.stall_if, b.if_rdata} !== {3'b100, 32'h8C01_0000}) begin
            n_fail++; $display("FAIL fetch_ack: got ack=%b dack=%b stall=%b data=%h expected 1 0 0 8c010000", b.if_ack, b.dm_ack, b.stall_if, b.if_rdata);
        end
        b.if_req = 1'b0;
        tick();
        n_checks++;
        if ({b.if_ack, b.mem_en, b.if_rdata} !== {2'b00, 32'h8C01_0000}) begin
            n_fail++; $display("FAIL fetch_after: got ack=%b en=%b data=%h expected 0 0 8c010000", b.if_ack, b.mem_en, b.if_rdata);
        end
    endtask

    task automatic test_priority();
        b.dm_we = 1'b1; b.dm_addr = 10'h010; b.dm_wdata = 32'hDEAD_BEEF; b.dm_req = 1'b1;
        b.if_addr = 10'h004; b.if_req = 1'b1;
        tick();
        n_checks++;
        if ({b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata, b.stall_if} !== {1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, 1'b1}) begin
            n_fail++; $display("FAIL prio_issue: got en=%b we=%b addr=%h wd=%h stall_if=%b expected 1 1 010 deadbeef 1", b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata, b.stall_if);
        end
        tick(); tick(); tick();
        n_checks++;
        if ({b.dm_ack, b.if_ack, b.stall_mem, b.stall_if, b.dm_rdata} !== {4'b1001, 32'h0}) begin
            n_fail++; $display("FAIL prio_store_ack: got dack=%b iack=%b smem=%b sif=%b drd=%h expected 1 0 0 1 0", b.dm_ack, b.if_ack, b.stall_mem, b.stall_if, b.dm_rdata);
        end
        b.dm_req = 1'b0; b.dm_we = 1'b0;
        tick();
        n_checks++;
        if (mem[10'h010] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL prio_store_mem: got %h expected deadbeef", mem[10'h010]);
        end
        tick();
        n_checks++;
        if ({b.mem_en, b.mem_we, b.mem_addr} !== {1'b1, 1'b0, 10'h004}) begin
            n_fail++; $display("FAIL prio_fetch_issue: got en=%b we=%b addr=%h expected 1 0 004", b.mem_en, b.mem_we, b.mem_addr);
        end
        tick(); tick(); tick();
        n_checks++;
        if ({b.if_ack, b.dm_ack, b.if_rdata} !== {2'b10, 32'h8C01_0000}) begin
            n_fail++; $display("FAIL prio_fetch_ack: got iack=%b dack=%b data=%h expected 1 0 8c010000", b.if_ack, b.dm_ack, b.if_rdata);
        end
        b.if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        b.dm_we = 1'b0; b.dm_addr = 10'h020; b.dm_req = 1'b1;
        tick();
        n_checks++;
        if ({b.mem_en, b.mem_we, b.mem_addr} !== {1'b1, 1'b0, 10'h020}) begin
            n_fail++; $display("FAIL load_issue: got en=%b we=%b addr=%h expected 1 0 020", b.mem_en, b.mem_we, b.mem_addr);
        end
        tick(); tick(); tick();
        n_checks++;
        if ({b.dm_ack, b.if_ack, b.dm_rdata} !== {2'b10, 32'h5}) begin
            n_fail++; $display("FAIL load_ack: got dack=%b iack=%b data=%h expected 1 0 00000005", b.dm_ack, b.if_ack, b.dm_rdata);
        end
        tick();
        n_checks++;
        if ({b.dm_ack, b.mem_en, b.dm_rdata} !== {2'b00, 32'h5}) begin
            n_fail++; $display("FAIL load_pulse: got dack=%b en=%b data=%h expected 0 0 00000005", b.dm_ack, b.mem_en, b.dm_rdata);
        end
        tick();
        n_checks++;
        if ({b.mem_en, b.mem_addr} !== {1'b1, 10'h020}) begin
            n_fail++; $display("FAIL b2b_issue: got en=%b addr=%h expected 1 020", b.mem_en, b.mem_addr);
        end
        tick(); tick(); tick();
        n_checks++;
        if (b.dm_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ack: got %b expected 1", b.dm_ack);
        end
        b.dm_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_dm;
        logic       found;
        logic       both;
        exp_dm = 10'b0111101111;
        both   = 1'b0;
        b.dm_we = 1'b0; b.dm_addr = 10'h020; b.dm_req = 1'b1;
        b.if_addr = 10'h004; b.if_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            for (int k = 0; k < 12 && !found; k++) begin
                tick();
                if (b.if_ack && b.dm_ack) both = 1'b1;
                if (b.mem_en) found = 1'b1;
            end
            n_checks++;
            if (!found || ((b.mem_addr == 10'h020) !== exp_dm[g])) begin
                n_fail++; $display("FAIL starve_grant%0d: got found=%b dm=%b expected found=1 dm=%b", g, found, (b.mem_addr == 10'h020), exp_dm[g]);
            end
        end
        b.dm_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (b.if_ack) found = 1'b1;
        end
        n_checks++;
        if ({found, both, b.if_rdata, b.dm_rdata} !== {2'b10, 32'h8C01_0000, 32'h5}) begin
            n_fail++; $display("FAIL starve_end: got ack=%b both=%b ird=%h drd=%h expected 1 0 8c010000 00000005", found, both, b.if_rdata, b.dm_rdata);
        end
        b.if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic spurious;
        logic got;
        int   n;
        b.if_addr = 10'h004; b.if_req = 1'b1;
        tick();
        n_checks++;
        if (b.mem_en !== 1'b1) begin
            n_fail++; $display("FAIL rmid_issue: got %b expected 1", b.mem_en);
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({b.mem_en, b.mem_we, b.if_ack, b.dm_ack, b.mem_addr, b.mem_wdata, b.if_rdata, b.dm_rdata} !== '0) begin
            n_fail++; $display("FAIL rmid_clear: got en=%b ack=%b%b addr=%h ird=%h drd=%h expected all 0", b.mem_en, b.if_ack, b.dm_ack, b.mem_addr, b.if_rdata, b.dm_rdata);
        end
        b.if_req = 1'b0;
        tick();
        reset = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (b.if_ack || b.dm_ack || b.mem_en) spurious = 1'b1;
        end
        n_checks++;
        if (spurious !== 1'b0) begin
            n_fail++; $display("FAIL rmid_no_ack: got spurious=%b expected 0", spurious);
        end
        b.if_req = 1'b1;
        got = 1'b0; n = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(); n++;
            if (b.if_ack) got = 1'b1;
        end
        n_checks++;
        if (!got || n != 4 || b.if_rdata !== 32'h8C01_0000) begin
            n_fail++; $display("FAIL rmid_refetch: got ack=%b latency=%0d data=%h expected 1 4 8c010000", got, n, b.if_rdata);
        end
        b.if_req = 1'b0;
        tick();
    endtask

    task automatic test_latency_cfg();
        int          n1;
        int          n15;
        logic [31:0] d1;
        logic [31:0] d15;
        n1 = 0; n15 = 0; d1 = '0; d15 = '0;
        b1.if_addr = 10'h004;  b1.if_req = 1'b1;
        b15.if_addr = 10'h004; b15.if_req = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (b1.if_ack && n1 == 0) begin n1 = n; d1 = b1.if_rdata; b1.if_req = 1'b0; end
            if (b15.if_ack && n15 == 0) begin n15 = n; d15 = b15.if_rdata; b15.if_req = 1'b0; end
        end
        n_checks++;
        if (n1 != 3 || d1 !== 32'h8C01_0000) begin
            n_fail++; $display("FAIL lat1_fetch: got latency=%0d data=%h expected 3 8c010000", n1, d1);
        end
        n_checks++;
        if (n15 != 17 || d15 !== 32'h8C01_0000) begin
            n_fail++; $display("FAIL lat15_fetch: got latency=%0d data=%h expected 17 8c010000", n15, d15);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[10'h004] = 32'h8C01_0000;
        mem[10'h020] = 32'h0000_0005;
        b.if_req = 1'b0;   b.if_addr = '0;   b.dm_req = 1'b0;   b.dm_we = 1'b0;   b.dm_addr = '0;   b.dm_wdata = '0;
        b1.if_req = 1'b0;  b1.if_addr = '0;  b1.dm_req = 1'b0;  b1.dm_we = 1'b0;  b1.dm_addr = '0;  b1.dm_wdata = '0;
        b15.if_req = 1'b0; b15.if_addr = '0; b15.dm_req = 1'b0; b15.dm_we = 1'b0; b15.dm_addr = '0; b15.dm_wdata = '0;
        reset = 1'b0;
        tick(); tick();
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_starvation();
        test_reset_mid();
        test_latency_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
